// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 types: branch predictor counter states and BTB entry layout
package rv32_pkg;

    // Smallest legal table (2 entries) leaves 29 tag bits; narrower tags are zero-extended.
    localparam int BP_MAX_TAG_W = 29;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_counter_e;

    typedef struct packed {
        logic                    valid;
        logic [BP_MAX_TAG_W-1:0] tag;
        logic [31:0]             target;
        bp_counter_e             counter;
    } bp_entry_t;

    localparam bp_counter_e BP_RESET_COUNTER = WNT;

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, execute resolve and feedback signals of the predictor
interface branch_predictor_if;

    logic        fetch_valid_i;
    logic [31:0] fetch_pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;

    logic        resolve_valid_i;
    logic [31:0] resolve_pc_i;
    logic        resolve_jump_i;
    logic        resolve_taken_i;
    logic [31:0] resolve_target_i;
    logic        resolve_pred_taken_i;
    logic [31:0] resolve_pred_target_i;

    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] branch_count_o;
    logic [31:0] mispredict_count_o;

    modport master (
        output fetch_valid_i, fetch_pc_i,
        output resolve_valid_i, resolve_pc_i, resolve_jump_i, resolve_taken_i,
        output resolve_target_i, resolve_pred_taken_i, resolve_pred_target_i,
        input  pred_taken_o, pred_target_o,
        input  mispredict_o, redirect_pc_o, branch_count_o, mispredict_count_o
    );

    modport slave (
        input  fetch_valid_i, fetch_pc_i,
        input  resolve_valid_i, resolve_pc_i, resolve_jump_i, resolve_taken_i,
        input  resolve_target_i, resolve_pred_taken_i, resolve_pred_target_i,
        output pred_taken_o, pred_target_o,
        output mispredict_o, redirect_pc_o, branch_count_o, mispredict_count_o
    );

endinterface

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - next state of a 2-bit saturating branch counter
module bp_sat_counter
    import rv32_pkg::*;
(
    input  bp_counter_e state,
    input  logic        taken,
    input  logic        force_strong,
    output bp_counter_e next_state
);

    always_comb begin
        next_state = state;
        if (force_strong) begin
            next_state = ST;
        end else if (taken) begin
            if (state != ST) next_state = bp_counter_e'(state + 2'd1);
        end else begin
            if (state != SNT) next_state = bp_counter_e'(state - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, trained by execute, redirects fetch
module branch_predictor
    import rv32_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input logic              clk_i,
    input logic              rst_ni,
    branch_predictor_if.slave bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    bp_entry_t                table_q [ENTRIES];
    logic [IDX_W-1:0]         fetch_idx, res_idx;
    logic [BP_MAX_TAG_W-1:0]  fetch_tag, res_tag;
    bp_entry_t                fetch_entry, res_entry, wr_entry;
    logic                     fetch_hit, res_hit, wr_en, mis;
    bp_counter_e              ctr_next;
    logic [31:0]              redirect_next;

    logic                     mispredict_q;
    logic [31:0]              redirect_q, branch_cnt_q, mis_cnt_q;

    // Lookup reads the flops directly, so a same-cycle update is not visible until next cycle.
    assign fetch_idx   = bp.fetch_pc_i[IDX_W+1:2];
    assign fetch_tag   = BP_MAX_TAG_W'(bp.fetch_pc_i[31 -: TAG_W]);
    assign fetch_entry = table_q[fetch_idx];
    assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == fetch_tag);

    assign bp.pred_taken_o  = bp.fetch_valid_i && fetch_hit && (fetch_entry.counter inside {WT, ST});
    assign bp.pred_target_o = bp.pred_taken_o ? fetch_entry.target : bp.fetch_pc_i + 32'd4;

    assign res_idx   = bp.resolve_pc_i[IDX_W+1:2];
    assign res_tag   = BP_MAX_TAG_W'(bp.resolve_pc_i[31 -: TAG_W]);
    assign res_entry = table_q[res_idx];
    assign res_hit   = res_entry.valid && (res_entry.tag == res_tag);

    bp_sat_counter u_ctr (
        .state       (res_entry.counter),
        .taken       (bp.resolve_taken_i),
        .force_strong(bp.resolve_jump_i),
        .next_state  (ctr_next)
    );

    always_comb begin
        wr_en    = 1'b0;
        wr_entry = res_entry;
        if (bp.resolve_valid_i) begin
            if (res_hit) begin
                wr_en            = 1'b1;
                wr_entry.counter = ctr_next;
                if (bp.resolve_jump_i || bp.resolve_taken_i) wr_entry.target = bp.resolve_target_i;
            end else if (bp.resolve_taken_i) begin
                // Allocation simply evicts whatever aliased into this slot.
                wr_en            = 1'b1;
                wr_entry.valid   = 1'b1;
                wr_entry.tag     = res_tag;
                wr_entry.target  = bp.resolve_target_i;
                wr_entry.counter = bp.resolve_jump_i ? ST : WT;
            end
        end
    end

    assign mis = (bp.resolve_taken_i != bp.resolve_pred_taken_i) ||
                 (bp.resolve_taken_i && (bp.resolve_target_i != bp.resolve_pred_target_i));
    assign redirect_next = bp.resolve_taken_i ? bp.resolve_target_i : bp.resolve_pc_i + 32'd4;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, counter: BP_RESET_COUNTER};
            end
        end else if (wr_en) begin
            table_q[res_idx] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            mispredict_q <= bp.resolve_valid_i && mis;
            if (bp.resolve_valid_i) begin
                redirect_q   <= redirect_next;
                branch_cnt_q <= branch_cnt_q + 32'd1;
                if (mis) mis_cnt_q <= mis_cnt_q + 32'd1;
            end
        end
    end

    assign bp.mispredict_o       = mispredict_q;
    assign bp.redirect_pc_o      = redirect_q;
    assign bp.branch_count_o     = branch_cnt_q;
    assign bp.mispredict_count_o = mis_cnt_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor: direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. The fetch stage queries it every cycle with the current PC. The execute stage's branch resolution (taken flag and target) trains it, and the predictor in turn produces the mispredict/redirect signal back to fetch. It is the consumer of branch-unit results and closes the loop between execute and fetch.

## Interface
- `ENTRIES`, 16: BTB depth; power of two, ≥2. `IDX_W = $clog2(ENTRIES)`.
- `clk_i`  in  1: clock, rising edge.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `fetch_valid_i`  in  1: lookup request this cycle.
- `fetch_pc_i`  in  32: PC being fetched.
- `pred_taken_o`  out  1: predict taken (combinational from table state).
- `pred_target_o`  out  32: predicted next PC.
- `resolve_valid_i`  in  1: a control-flow instruction resolved this cycle.
- `resolve_pc_i`  in  32: PC of resolved instruction.
- `resolve_jump_i`  in  1: instruction is an unconditional jump.
- `resolve_taken_i`  in  1: actual outcome.
- `resolve_target_i`  in  32: actual taken target.
- `resolve_pred_taken_i`  in  1: prediction that travelled with the instruction.
- `resolve_pred_target_i`  in  32: predicted target that travelled with it.
- `mispredict_o`  out  1: registered, one-cycle pulse.
- `redirect_pc_o`  out  32: registered correct next PC; valid when `mispredict_o`=1.
- `branch_count_o`  out  32: resolved-instruction count, wraps.
- `mispredict_count_o`  out  32: mispredict count, wraps.

## Operation
- Index = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`. Entry holds valid, tag, 32-bit target, and a 2-bit counter: SNT=00, WNT=01, WT=10, ST=11.
- Lookup:
  - hit = valid && tag match.
  - `pred_taken_o` = `fetch_valid_i` && hit && `counter[1]`.
  - `pred_target_o` = stored target when `pred_taken_o` is 1; otherwise `fetch_pc_i`+4 (mod 2^32).
- Update, on `resolve_valid_i` only:
  - Hit, conditional branch: taken → counter saturating +1 and target ← `resolve_target_i`; not-taken → counter saturating −1, target unchanged.
  - Hit, jump: counter ← ST, target ← `resolve_target_i`.
  - Miss and taken: allocate, overwriting any aliasing entry. Set valid=1, new tag, target ← `resolve_target_i`, counter ← WT (ST for a jump).
  - Miss and not taken: no table change.
- Mispredict = (`resolve_taken_i` != `resolve_pred_taken_i`) || (`resolve_taken_i` && `resolve_target_i` != `resolve_pred_target_i`).
- `redirect_pc_o` = `resolve_taken_i` ? `resolve_target_i` : `resolve_pc_i`+4.
- `branch_count_o` increments on every `resolve_valid_i`. `mispredict_count_o` increments when a mispredict is detected.

## Timing
- Reset (async assert, sync-safe deassert):
  - All valid bits 0, counters WNT, targets and tags 0.
  - `mispredict_o`=0, `redirect_pc_o`=0, both counters 0.
  - `pred_taken_o`=0; `pred_target_o` = `fetch_pc_i`+4.
- Lookup has zero latency from table flops. A table update written at edge N is first visible to a lookup in cycle N+1.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update contents. There is no bypass.
- `mispredict_o` and `redirect_pc_o` are registered one cycle after `resolve_valid_i`. `mispredict_o` is high for exactly one cycle per mispredicted resolution. Back-to-back resolutions give back-to-back independent pulses.
- `resolve_valid_i`=0: all resolve inputs are ignored; `mispredict_o` is 0 the next cycle.
- Reset asserted mid-operation: all state clears immediately, and any pending `mispredict_o` pulse is dropped.
- No backpressure exists on either port. The block accepts one lookup and one resolve every cycle.

## Structure
- `rv32_pkg` additions:
  - `bp_counter_e`: 2-bit enum SNT/WNT/WT/ST.
  - `bp_entry_t`: packed struct with valid, tag, target, counter.
  - `BP_RESET_COUNTER` = WNT.
- Tag width derives from `ENTRIES` inside the module; the package struct uses a maximal tag width parameterized by a localparam.
- One sub-module, `bp_sat_counter`: combinational next-state for the 2-bit counter. Inputs: current state, taken, force_strong. Output: next state.
- Table is flops (no RAM macro).

## Test plan
- Reset, then `fetch_valid_i`=1, `fetch_pc_i`=0x100 → `pred_taken_o`=0, `pred_target_o`=0x104; counters 0.
- Resolve pc=0x100 branch taken, target 0x80, pred_taken=0 → next cycle `mispredict_o`=1 and `redirect_pc_o`=0x80, `mispredict_count_o`=1. Following fetch of 0x100 → `pred_taken_o`=1, `pred_target_o`=0x80.
- Hysteresis: from the allocated WT state, resolve 0x100 taken, taken, then not-taken → lookup still predicts taken. One more not-taken → `pred_taken_o`=0, `pred_target_o`=0x104.
- Aliasing: with 0x100 allocated, resolve 0x140 (same index 0) not-taken → 0x100 entry unchanged. Resolve 0x140 taken, target 0x200 → fetch 0x100 misses (0x104), fetch 0x140 predicts 0x200.
- Target mismatch: predicted taken to 0x80, actual taken to 0x90 → `mispredict_o`=1, `redirect_pc_o`=0x90. Next lookup of 0x100 gives 0x90. Same-cycle lookup still gives 0x80.
- Drive `rst_ni` low in the cycle after a mispredicting resolve → `mispredict_o` stays 0, all entries invalid, counters 0.
